// File: rtl/mem_bus_arbiter.sv
// Shares one memory port among fetch(0), exec(1), DMA(2). A request in cycle n gets its grant and access in n+1, and read data in n+2.
// Losers wait with req held. An owner's lock pins the grant. A fetcher that has waited STARVE_LIMIT cycles is forced to win.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int REG_WIDTH    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              req,
    input  logic [2:0]              lock,
    input  logic [2:0]              we,
    input  logic [3*ADDR_WIDTH-1:0] addr,
    input  logic [3*REG_WIDTH-1:0]  wdata,
    output logic [2:0]              gnt,
    output logic [2:0]              rvalid,
    output logic [REG_WIDTH-1:0]    rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [REG_WIDTH-1:0]    mem_wdata,
    input  logic [REG_WIDTH-1:0]    mem_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        OWN_FETCH = 3'b001,
        OWN_EXEC  = 3'b010,
        OWN_DMA   = 3'b100
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      rd_pending_q, rd_pending_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [2:0]      access;
    logic            starved;

    assign gnt     = state_q;
    assign access  = gnt & req;
    // Only a fetcher that is actually waiting may use the starvation override,
    // so it wins exactly once before the counter has cleared.
    assign starved = req[0] && !gnt[0] && (starve_cnt_q == CW'(STARVE_LIMIT));

    always_comb begin
        state_d      = IDLE;
        rd_pending_d = access & ~we;
        starve_cnt_d = '0;
        if ((gnt & req & lock) != 3'b000) begin
            state_d = state_q;
        end else if (starved) begin
            state_d = OWN_FETCH;
        end else if (req[2]) begin
            state_d = OWN_DMA;
        end else if (req[1]) begin
            state_d = OWN_EXEC;
        end else if (req[0]) begin
            state_d = OWN_FETCH;
        end
        if (req[0] && !gnt[0]) begin
            starve_cnt_d = (starve_cnt_q == CW'(STARVE_LIMIT)) ? starve_cnt_q
                                                                : starve_cnt_q + CW'(1);
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (access[i]) begin
                mem_en    = 1'b1;
                mem_we    = we[i];
                mem_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata = wdata[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign rvalid = rd_pending_q;
    assign rdata  = (rd_pending_q != 3'b000) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_pending_q <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_pending_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a synchronous ROM behind the memory port.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, lock, we;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt, rvalid;
    logic [7:0]  rdata, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;

    int compared   = 0;
    int mismatched = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .REG_WIDTH(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // 8000 -> A9, 0010 -> 4A, 0020 -> 7A, 0030 -> 6A
    function automatic logic [7:0] rom(input logic [15:0] a);
        if (a == 16'h8000) return 8'hA9;
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rom(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each step starts just after the negedge: registered outputs are stable,
    // and inputs driven here are sampled by the next rising edge.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req = 3'b000; lock = 3'b000; we = 3'b000;
        addr = '0; wdata = '0;
        repeat (2) next_cycle();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);

        // Single fetcher read
        next_cycle();
        reset = 1'b0; req = 3'b001; addr = {16'h0000, 16'h0000, 16'h8000};
        #1 chk("rd_c0_no_access", 32'(mem_en), 32'h0);
        next_cycle();
        chk("rd_c1_gnt", 32'(gnt), 32'h1);
        chk("rd_c1_mem_en", 32'(mem_en), 32'h1);
        chk("rd_c1_mem_we", 32'(mem_we), 32'h0);
        chk("rd_c1_mem_addr", 32'(mem_addr), 32'h8000);
        chk("rd_c1_rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        chk("rd_c2_rvalid", 32'(rvalid), 32'h1);
        chk("rd_c2_rdata", 32'(rdata), 32'hA9);
        req = 3'b000;
        #1 chk("rd_c2_noreq_mem_en", 32'(mem_en), 32'h0);
        chk("rd_c2_gnt_kept", 32'(gnt), 32'h1);
        next_cycle();
        chk("rd_c3_gnt", 32'(gnt), 32'h0);
        chk("rd_c3_rvalid", 32'(rvalid), 32'h0);
        chk("rd_c3_rdata", 32'(rdata), 32'h0);

        // Priority, then starvation of the fetcher behind exec
        next_cycle();
        req = 3'b111; addr = {16'h0030, 16'h0020, 16'h0010};
        next_cycle();
        chk("pr_c1_gnt", 32'(gnt), 32'h4);
        chk("pr_c1_mem_addr", 32'(mem_addr), 32'h0030);
        next_cycle();
        chk("pr_c2_gnt", 32'(gnt), 32'h4);
        chk("pr_c2_rvalid", 32'(rvalid), 32'h4);
        chk("pr_c2_rdata", 32'(rdata), 32'h6A);
        next_cycle();
        chk("pr_c3_gnt", 32'(gnt), 32'h4);
        req = 3'b011;
        next_cycle();
        chk("pr_c4_gnt", 32'(gnt), 32'h2);
        chk("pr_c4_mem_addr", 32'(mem_addr), 32'h0020);
        chk("pr_c4_rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        chk("st_c5_gnt", 32'(gnt), 32'h1);
        chk("st_c5_mem_addr", 32'(mem_addr), 32'h0010);
        chk("st_c5_rvalid", 32'(rvalid), 32'h2);
        chk("st_c5_rdata", 32'(rdata), 32'h7A);
        next_cycle();
        chk("st_c6_gnt", 32'(gnt), 32'h2);
        chk("st_c6_rvalid", 32'(rvalid), 32'h1);
        chk("st_c6_rdata", 32'(rdata), 32'h4A);
        next_cycle();
        chk("st_c7_gnt", 32'(gnt), 32'h2);
        chk("st_c7_rvalid", 32'(rvalid), 32'h2);
        req = 3'b000;
        next_cycle();
        chk("st_c8_gnt", 32'(gnt), 32'h0);
        chk("st_c8_rvalid", 32'(rvalid), 32'h0);

        // Exec locked write pair with DMA waiting, then DMA write
        next_cycle();
        req = 3'b010; lock = 3'b010; we = 3'b010;
        addr = {16'h0000, 16'h0200, 16'h0000}; wdata = {8'h00, 8'h55, 8'h00};
        next_cycle();
        chk("lk_c1_gnt", 32'(gnt), 32'h2);
        chk("lk_c1_mem_we", 32'(mem_we), 32'h1);
        chk("lk_c1_mem_addr", 32'(mem_addr), 32'h0200);
        chk("lk_c1_mem_wdata", 32'(mem_wdata), 32'h55);
        req = 3'b110; we = 3'b110;
        addr = {16'h2004, 16'h0200, 16'h0000}; wdata = {8'h3C, 8'h55, 8'h00};
        next_cycle();
        chk("lk_c2_gnt_held", 32'(gnt), 32'h2);
        chk("lk_c2_rvalid", 32'(rvalid), 32'h0);
        lock = 3'b000;
        addr = {16'h2004, 16'h0201, 16'h0000}; wdata = {8'h3C, 8'h66, 8'h00};
        #1 chk("lk_c2_mem_addr", 32'(mem_addr), 32'h0201);
        chk("lk_c2_mem_wdata", 32'(mem_wdata), 32'h66);
        chk("lk_c2_mem_we", 32'(mem_we), 32'h1);
        next_cycle();
        chk("wr_c3_gnt", 32'(gnt), 32'h4);
        chk("wr_c3_mem_we", 32'(mem_we), 32'h1);
        chk("wr_c3_mem_addr", 32'(mem_addr), 32'h2004);
        chk("wr_c3_mem_wdata", 32'(mem_wdata), 32'h3C);
        chk("wr_c3_rvalid", 32'(rvalid), 32'h0);
        req = 3'b100;
        next_cycle();
        req = 3'b000;
        #1 chk("wr_c4_gnt", 32'(gnt), 32'h4);
        chk("wr_c4_mem_en", 32'(mem_en), 32'h0);
        chk("wr_c4_rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        chk("wr_c5_gnt", 32'(gnt), 32'h0);
        chk("wr_c5_rvalid", 32'(rvalid), 32'h0);

        // Reset in the cycle after a read grant
        next_cycle();
        req = 3'b010; we = 3'b000; addr = {16'h0000, 16'h0020, 16'h0000};
        next_cycle();
        chk("rr_c1_gnt", 32'(gnt), 32'h2);
        chk("rr_c1_mem_en", 32'(mem_en), 32'h1);
        next_cycle();
        chk("rr_c2_rvalid", 32'(rvalid), 32'h2);
        chk("rr_c2_rdata", 32'(rdata), 32'h7A);
        reset = 1'b1;
        next_cycle();
        chk("rr_c3_gnt", 32'(gnt), 32'h0);
        chk("rr_c3_rvalid", 32'(rvalid), 32'h0);
        chk("rr_c3_rdata", 32'(rdata), 32'h0);
        chk("rr_c3_mem_en", 32'(mem_en), 32'h0);
        reset = 1'b0; req = 3'b000;
        next_cycle();
        chk("rr_c4_gnt", 32'(gnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory bus arbiter that shares the CPU's one 16-bit address / 8-bit data memory port among three requesters: the instruction fetcher (index 0), the execute unit (index 1) and the OAM DMA engine (index 2). It issues at most one access per cycle and returns read data to the owning requester. It supports bus locking for multi-byte sequences and guarantees the fetcher cannot be starved by back-to-back priority traffic. It sits between the CPU core and the memory map decoder.

## Interface
- ADDR_WIDTH, 16, memory address width
- REG_WIDTH, 8, data width
- STARVE_LIMIT, 4, cycles the fetcher may wait with req high before it is forced to win

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  3  per-requester access request
- lock  in  3  per-requester hold-bus request, honoured only while that requester owns the bus
- we  in  3  per-requester write enable, 1=write
- addr  in  3*ADDR_WIDTH  packed addresses, requester i at [i*16 +: 16]
- wdata  in  3*REG_WIDTH  packed write data, requester i at [i*8 +: 8]
- gnt  out  3  registered one-hot grant, at most one bit set
- rvalid  out  3  read data valid for requester i
- rdata  out  REG_WIDTH  read data, shared by all requesters, qualified by rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  REG_WIDTH  memory write data
- mem_rdata  in  REG_WIDTH  synchronous-RAM read data, valid the cycle after a read strobe

## Operation
- States: IDLE (gnt=0) and OWN(i) (gnt[i]=1). gnt, rd_pending[2:0] and starve_cnt are the only registered state.
- Arbitration runs every edge and selects the owner for the next cycle.
  - Lock rule: if the current owner i has req[i]=1 and lock[i]=1, it stays OWN(i) unconditionally.
  - Starvation rule: otherwise, if req[0]=1 and starve_cnt==STARVE_LIMIT, the fetcher wins.
  - Fixed priority: otherwise priority is DMA(2) > exec(1) > fetch(0) among asserted req.
  - If no req is asserted, the next state is IDLE.
- Access: in a cycle with gnt[i]=1 and req[i]=1, mem_en=1 and mem_we=we[i]. mem_addr and mem_wdata are taken from requester i's slice.
- If gnt[i]=1 but req[i]=0, there is no access.
- Outside an access, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0. These outputs are combinational from gnt and the inputs.
- Read return: on an access with we=0, rd_pending[i] is set for exactly the next cycle. rvalid=rd_pending. rdata=mem_rdata when any rvalid is set, else 0.
- Writes never assert rvalid.
- starve_cnt: increments when req[0]=1 and gnt[0]=0, saturating at STARVE_LIMIT. It clears when gnt[0]=1 or req[0]=0.
- A lock held by another requester is never broken, including by the starvation rule. Requesters must bound their lock duration; DMA drops lock after each 2-byte read/write pair.

## Timing
- Reset, and every output while reset is asserted (values apply from the first edge with reset=1):
  - gnt=0, rd_pending=0, starve_cnt=0.
  - Therefore mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, rdata=0.
- Reset mid-access: any outstanding rvalid is dropped and the grant is lost. Requesters must re-request.
- Latency:
  - req high in cycle n gives gnt and the memory access in cycle n+1.
  - Read data and rvalid appear in cycle n+2.
  - A write completes in cycle n+1.
- Throughput: an uncontested requester holding req continuously is granted every cycle, one access per cycle. Read responses are pipelined one per cycle.
- Handshake: a requester holds addr, we and wdata stable from the req assertion until the cycle in which its gnt is high. It may change them every granted cycle for streaming.
- Simultaneous req on all three with no lock and starve_cnt<limit: DMA is granted.
- An owner deasserting req while granted: no access that cycle, and arbitration re-runs at the same edge.
- Grant switching: the grant can move between requesters on consecutive cycles with no idle bubble.

## Test plan
- Reset then single fetcher read: req=001, addr0=16'h8000, RAM[8000]=8'hA9 -> gnt=001 in cycle 1, mem_addr=8000 and mem_en=1 in cycle 1, rvalid=001 and rdata=A9 in cycle 2.
- Priority: req=111 from cycle 0 with no lock -> gnt=100 from cycle 1 onward. With req[2] dropped at cycle 3, gnt=010 at cycle 4.
- Lock: exec owns with lock=1 and req=1 while DMA asserts req -> gnt stays 010 until lock drops. Exec writes 8'h55 to 16'h0200 and 8'h66 to 16'h0201 on consecutive cycles.
- Starvation: exec req continuously, fetch req continuously, STARVE_LIMIT=4 -> fetch granted exactly once after 4 waiting cycles, starve_cnt returns to 0, then exec resumes.
- Write: DMA req with we=1, addr=16'h2004, wdata=8'h3C -> mem_we=1, mem_wdata=3C and mem_addr=2004 for one cycle, and rvalid stays 000.
- Reset mid-read: assert reset in the cycle after a read grant -> rvalid=000 and gnt=000 on the next cycle, with no stale rdata.
